// File: rtl/smart_fan_pkg.sv
// Shared types and constants for the smart fan temperature path.
package smart_fan_pkg;

  // Fahrenheit-to-Celsius converter control states.
  typedef enum logic [1:0] {
    F2C_IDLE,
    F2C_DIV,
    F2C_DONE
  } f2c_state_t;

  // temp_c = (temp_f - F_OFFSET) * F2C_MUL / F2C_DIVISOR
  localparam int unsigned F_OFFSET    = 32;
  localparam int unsigned F2C_MUL     = 5;
  // Named apart from the F2C_DIV state to keep the package namespace unambiguous.
  localparam int unsigned F2C_DIVISOR = 9;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// o_done is high during the final step; o_quotient/o_remainder carry that
// step's result so the caller can capture it on the same edge.
module serial_divider #(
  parameter int unsigned DIV_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  localparam int unsigned CNT_W = $clog2(DIV_W);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_rem;
  // Holds remaining dividend bits in the top, accumulated quotient bits in the bottom.
  logic [DIV_W-1:0] r_dvd;

  logic [DIV_W:0]   w_rem_sh;
  logic [DIV_W-1:0] w_rem_sub;
  logic             w_ge;
  logic [DIV_W-1:0] w_rem_nx;
  logic [DIV_W-1:0] w_dvd_nx;

  // One restoring step: shift rem:dividend left, subtract divisor if it fits.
  always_comb begin
    w_rem_sh  = {r_rem, r_dvd[DIV_W-1]};
    w_ge      = (w_rem_sh >= {1'b0, i_divisor});
    w_rem_sub = w_rem_sh[DIV_W-1:0] - i_divisor;
    w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[DIV_W-1:0];
    w_dvd_nx  = {r_dvd[DIV_W-2:0], w_ge};
  end

  // Load on start, then iterate DIV_W steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(DIV_W - 1);
      r_rem  <= '0;
      r_dvd  <= i_dividend;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_dvd_nx;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_busy && (r_cnt == '0);
  assign o_quotient  = w_dvd_nx;
  assign o_remainder = w_rem_nx;

endmodule

// File: rtl/temp_f_to_c.sv
// Sequential Fahrenheit-to-Celsius converter with valid/ready handshakes.
// temp_c = trunc_toward_zero((temp_f - 32) * 5 / 9), computed as a signed
// magnitude so the divider only ever sees unsigned operands.
module temp_f_to_c
  import smart_fan_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  temp_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] temp_c
);

  // |temp_f - 32| * 5 always fits in IN_W+3 bits.
  localparam int unsigned DIV_W = IN_W + 3;

  f2c_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_neg;
  logic [OUT_W-1:0] r_temp_c;

  logic [DIV_W-1:0] w_f_ext;
  logic             w_neg;
  logic [DIV_W-1:0] w_mag;
  logic [DIV_W-1:0] w_dividend;
  logic             w_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [DIV_W-1:0] w_quotient;
  logic [DIV_W-1:0] w_remainder;
  logic [OUT_W-1:0] w_q;
  logic             w_unused;

  // Sign and scaled magnitude of the offset-corrected input.
  always_comb begin
    w_f_ext    = DIV_W'(temp_f);
    w_neg      = (w_f_ext < DIV_W'(F_OFFSET));
    w_mag      = w_neg ? (DIV_W'(F_OFFSET) - w_f_ext) : (w_f_ext - DIV_W'(F_OFFSET));
    w_dividend = w_mag * DIV_W'(F2C_MUL);
    w_q        = OUT_W'(w_quotient);
  end

  // r_in_ready is high only in IDLE, so this is the accepting edge.
  assign w_start = in_valid && r_in_ready;

  serial_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (DIV_W'(F2C_DIVISOR)),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient),
    .o_remainder(w_remainder)
  );

  // Remainder is discarded (truncation); busy is implied by the FSM state.
  assign w_unused = ^{w_div_busy, w_remainder};

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= F2C_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_neg       <= 1'b0;
      r_temp_c    <= '0;
    end else begin
      case (r_state)
        F2C_IDLE: begin
          if (in_valid) begin
            r_neg      <= w_neg;
            r_in_ready <= 1'b0;
            r_state    <= F2C_DIV;
          end
        end
        F2C_DIV: begin
          if (w_div_done) begin
            r_temp_c    <= r_neg ? (-w_q) : w_q;
            r_out_valid <= 1'b1;
            r_state     <= F2C_DONE;
          end
        end
        F2C_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= F2C_IDLE;
          end
        end
        default: begin
          r_state     <= F2C_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign temp_c    = r_temp_c;

endmodule

// File: tb/tb_temp_f_to_c.sv
// Scoreboard bench for temp_f_to_c: accepted inputs push a model result,
// a negedge monitor pops and compares on every output handshake.
module tb_temp_f_to_c;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] temp_f    = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] temp_c;

  always #5 clk = ~clk;

  temp_f_to_c #(
    .IN_W (8),
    .OUT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .temp_f   (temp_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .temp_c   (temp_c)
  );

  typedef struct {
    int value;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  int   rise_q[$];
  int   cyc        = 0;
  int   tests      = 0;
  int   fails      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, SV division truncates toward zero.
  function automatic int ref_f2c(input int f);
    return ((f - 32) * 5) / 9;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: flush on reset, check latency on rise, compare on handshake, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        if (sb_q.size() == 0) check("spurious_out_valid", 1, 0);
        else check("latency", cyc - sb_q[0].acc, 11);
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        check("temp_c", int'($signed(temp_c)), sb_q[0].value);
        void'(sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{value: ref_f2c(int'(temp_f)), acc: cyc + 1});
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input int f);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    temp_f   = 8'(f);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int dir_f[6]   = '{212, 32, 31, 0, 255, 98};
  int dir_c[6]   = '{100, 0, 0, -17, 123, 36};
  int stream_f[3] = '{212, 32, 0};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_temp_c", int'(temp_c), 0);
    rst = 1'b0;

    // Directed points, results also compared with literal expectations.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(dir_f[i]);
      wait_valid();
      check($sformatf("direct_%0d", dir_f[i]), int'($signed(temp_c)), dir_c[i]);
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: result must hold and new requests be ignored.
    out_ready = 1'b0;
    send(98);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      temp_f   = 8'($urandom);
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_temp_c", int'($signed(temp_c)), 36);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    drain();

    // Streaming with in_valid and out_ready held high.
    rise_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit ok;
      ok     = 1'b0;
      temp_f = 8'(stream_f[i]);
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check("stream_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("stream_period_0", rise_q[1] - rise_q[0], 13);
      check("stream_period_1", rise_q[2] - rise_q[1], 13);
    end

    // Reset in the middle of a division.
    send(100);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_temp_c", int'(temp_c), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    send(50);
    wait_valid();
    check("after_rst_50", int'($signed(temp_c)), 10);
    drain();

    // Exhaustive sweep.
    for (int f = 0; f < 256; f++) send(f);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      temp_f    = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
